// File: rtl/dm_store_buffer_pkg.sv
// Shared types and helpers for the data-memory store buffer.
package dm_store_buffer_pkg;

    localparam logic [3:0]  BE_WORD  = 4'hF;
    localparam int unsigned DM_IDX_W = 10;

    // One buffered store, as written to the data memory.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] pc;
    } sb_entry_t;

    // Word index addr[idx_w+1:2], zero-extended to 32 bits.
    function automatic logic [31:0] word_idx(input logic [31:0] addr, input int unsigned idx_w);
        logic [31:0] mask;
        mask = (32'd1 << idx_w) - 32'd1;
        return (addr >> 2) & mask;
    endfunction

endpackage

// File: rtl/dm_store_buffer_if.sv
// MEM-stage store/load request bus and data-memory write port of the store buffer.
interface dm_store_buffer_if;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_wdata;
    logic [3:0]  st_be;
    logic [31:0] st_pc;
    logic        st_ready;

    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_stall;
    logic        ld_fwd_valid;
    logic [31:0] ld_fwd_data;

    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wd;
    logic [3:0]  dm_be;
    logic [31:0] dm_pc;
    logic        empty;

    // Pipeline side: issues stores/loads, observes the memory port.
    modport master (
        output st_valid, st_addr, st_wdata, st_be, st_pc, ld_valid, ld_addr,
        input  st_ready, ld_stall, ld_fwd_valid, ld_fwd_data,
        input  dm_we, dm_addr, dm_wd, dm_be, dm_pc, empty
    );

    // Store buffer side.
    modport slave (
        input  st_valid, st_addr, st_wdata, st_be, st_pc, ld_valid, ld_addr,
        output st_ready, ld_stall, ld_fwd_valid, ld_fwd_data,
        output dm_we, dm_addr, dm_wd, dm_be, dm_pc, empty
    );
endinterface

// File: rtl/dm_sb_match.sv
// Word-index comparator over N age-ordered candidates (index 0 oldest);
// reports whether any valid candidate matches and returns the youngest match.
module dm_sb_match
    import dm_store_buffer_pkg::*;
#(
    parameter int unsigned N     = 5,
    parameter int unsigned IDX_W = DM_IDX_W
) (
    input  logic [31:0] key_addr_i,
    input  sb_entry_t   ent_i [N],
    input  logic [N-1:0] vld_i,
    output logic        hit_c_o,
    output sb_entry_t   ent_c_o
);

    // Later (younger) matches overwrite earlier ones.
    always_comb begin
        hit_c_o = 1'b0;
        ent_c_o = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (vld_i[i] && (word_idx(ent_i[i].addr, IDX_W) == word_idx(key_addr_i, IDX_W))) begin
                hit_c_o = 1'b1;
                ent_c_o = ent_i[i];
            end
        end
    end

endmodule

// File: rtl/dm_store_buffer.sv
// Posted-write store buffer: queues MEM-stage stores in a circular FIFO,
// drains one per cycle to the data memory, stalls loads that hit a pending
// store. Optional full-word forwarding: DM_STORE_BUFFER_LOAD_FWD_EN.
module dm_store_buffer
    import dm_store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned IDX_W = DM_IDX_W
) (
    input  logic               clk,
    input  logic               reset,
    dm_store_buffer_if.slave   bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned NCAND = DEPTH + 1;

    sb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    sb_entry_t        drain_q, drain_d;
    logic             dm_we_q, dm_we_d;

    logic      push;
    logic      pop;
    sb_entry_t st_ent;

    sb_entry_t        cand [NCAND];
    logic [NCAND-1:0] cand_vld;
    logic             match_hit;
    sb_entry_t        match_ent;

    // Handshake and FIFO next-state.
    always_comb begin
        st_ent   = '{addr: bus.st_addr, wdata: bus.st_wdata, be: bus.st_be, pc: bus.st_pc};
        push     = bus.st_valid && (count_q != CNT_W'(DEPTH));
        pop      = (count_q != '0);
        head_d   = pop  ? head_q + PTR_W'(1) : head_q;
        tail_d   = push ? tail_q + PTR_W'(1) : tail_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        drain_d  = pop ? mem_q[head_q] : drain_q;
        dm_we_d  = pop;
    end

    // Entry storage; no reset needed, validity comes from count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= st_ent;
        end
    end

    // Pointers, count and drain register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            drain_q <= '0;
            dm_we_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            drain_q <= drain_d;
            dm_we_q <= dm_we_d;
        end
    end

    // Age-ordered candidate list: drain register first, then FIFO head to tail.
    always_comb begin
        cand[0]     = drain_q;
        cand_vld[0] = dm_we_q;
        for (int k = 0; k < int'(DEPTH); k++) begin
            cand[k+1]     = mem_q[head_q + PTR_W'(k)];
            cand_vld[k+1] = (CNT_W'(k) < count_q);
        end
    end

    dm_sb_match #(
        .N     (NCAND),
        .IDX_W (IDX_W)
    ) u_match (
        .key_addr_i (bus.ld_addr),
        .ent_i      (cand),
        .vld_i      (cand_vld),
        .hit_c_o    (match_hit),
        .ent_c_o    (match_ent)
    );

    // Load hazard resolution.
`ifdef DM_STORE_BUFFER_LOAD_FWD_EN
    logic fwd_ok;
    always_comb begin
        fwd_ok           = bus.ld_valid && match_hit && (match_ent.be == BE_WORD);
        bus.ld_fwd_valid = fwd_ok;
        bus.ld_fwd_data  = fwd_ok ? match_ent.wdata : 32'd0;
        bus.ld_stall     = bus.ld_valid && match_hit && !fwd_ok;
    end
`else
    logic unused_match_ent;
    assign unused_match_ent = ^match_ent;
    always_comb begin
        bus.ld_fwd_valid = 1'b0;
        bus.ld_fwd_data  = 32'd0;
        bus.ld_stall     = bus.ld_valid && match_hit;
    end
`endif

    // Status and data-memory write port.
    always_comb begin
        bus.st_ready = (count_q != CNT_W'(DEPTH));
        bus.empty    = (count_q == '0) && !dm_we_q;
        bus.dm_we    = dm_we_q;
        bus.dm_addr  = drain_q.addr;
        bus.dm_wd    = drain_q.wdata;
        bus.dm_be    = drain_q.be;
        bus.dm_pc    = drain_q.pc;
    end

    // Only one MEM-stage instruction per cycle; the store wins if both appear.
    a_no_st_ld: assert property (@(posedge clk) disable iff (!reset)
                                 !(bus.st_valid && bus.ld_valid))
        else $error("dm_store_buffer: store and load in the same cycle");

endmodule

// File: tb/tb_dm_store_buffer.sv
// Bench for dm_store_buffer: directed scenarios plus random traffic checked
// against a queue-based model of pending stores.
module tb_dm_store_buffer;

    localparam int unsigned DEPTH = 4;
`ifdef DM_STORE_BUFFER_LOAD_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        logic [31:0] pc;
    } st_t;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    st_t  q[$];
    st_t  fl;
    bit   fl_v;

    dm_store_buffer_if bus ();

    dm_store_buffer #(.DEPTH(DEPTH), .IDX_W(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] widx(input logic [31:0] a);
        return (a >> 2) & 32'h3FF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        fl   = '{a: 32'd0, d: 32'd0, be: 4'd0, pc: 32'd0};
        fl_v = 1'b0;
    endtask

    // Compare every output against the model for the current inputs.
    task automatic check_all(input string tag, input bit lv, input logic [31:0] la);
        bit   hit;
        st_t  y;
        bit   fwd;
        hit = 1'b0;
        y   = fl;
        if (fl_v && widx(fl.a) == widx(la)) begin
            hit = 1'b1;
            y   = fl;
        end
        foreach (q[i]) begin
            if (widx(q[i].a) == widx(la)) begin
                hit = 1'b1;
                y   = q[i];
            end
        end
        fwd = lv && hit && FWD_EN && (y.be == 4'hF);
        chk({tag, ".st_ready"}, 32'(bus.st_ready), 32'(q.size() != DEPTH));
        chk({tag, ".ld_stall"}, 32'(bus.ld_stall), 32'(lv && hit && !fwd));
        chk({tag, ".fwd_v"},    32'(bus.ld_fwd_valid), 32'(fwd));
        chk({tag, ".fwd_d"},    bus.ld_fwd_data, fwd ? y.d : 32'd0);
        chk({tag, ".dm_we"},    32'(bus.dm_we), 32'(fl_v));
        chk({tag, ".dm_addr"},  bus.dm_addr, fl.a);
        chk({tag, ".dm_wd"},    bus.dm_wd, fl.d);
        chk({tag, ".dm_be"},    32'(bus.dm_be), 32'(fl.be));
        chk({tag, ".dm_pc"},    bus.dm_pc, fl.pc);
        chk({tag, ".empty"},    32'(bus.empty), 32'(q.size() == 0 && !fl_v));
    endtask

    // One cycle: drive at negedge, check, then advance the model across posedge.
    task automatic step(input string tag, input bit sv, input logic [31:0] sa,
                        input logic [31:0] sd, input logic [3:0] sb, input logic [31:0] spc,
                        input bit lv, input logic [31:0] la);
        bit  push;
        st_t s;
        @(negedge clk);
        bus.st_valid = sv;
        bus.st_addr  = sa;
        bus.st_wdata = sd;
        bus.st_be    = sb;
        bus.st_pc    = spc;
        bus.ld_valid = lv;
        bus.ld_addr  = la;
        #1;
        check_all(tag, lv, la);
        push = sv && (q.size() != DEPTH);
        s    = '{a: sa, d: sd, be: sb, pc: spc};
        @(posedge clk);
        if (q.size() > 0) begin
            fl   = q.pop_front();
            fl_v = 1'b1;
        end else begin
            fl_v = 1'b0;
        end
        if (push) q.push_back(s);
        #1;
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 32'd0, 32'd0, 4'd0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic store(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        step(tag, 1'b1, a, d, be, 32'h0000_1000 + a, 1'b0, 32'd0);
    endtask

    task automatic load(input string tag, input logic [31:0] a);
        step(tag, 1'b0, 32'd0, 32'd0, 4'd0, 32'd0, 1'b1, a);
    endtask

    initial begin
        clk          = 1'b0;
        reset        = 1'b0;
        bus.st_valid = 1'b0;
        bus.st_addr  = '0;
        bus.st_wdata = '0;
        bus.st_be    = '0;
        bus.st_pc    = '0;
        bus.ld_valid = 1'b0;
        bus.ld_addr  = '0;
        model_reset();

        // Reset values.
        #2;
        chk("rst.st_ready", 32'(bus.st_ready), 32'd1);
        chk("rst.empty",    32'(bus.empty), 32'd1);
        chk("rst.dm_we",    32'(bus.dm_we), 32'd0);
        chk("rst.dm_addr",  bus.dm_addr, 32'd0);
        check_all("rst", 1'b0, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Single store latency.
        store("t1.s", 32'h10, 32'hDEADBEEF, 4'hF);
        idle("t1.e1");
        chk("t1.dm_we",   32'(bus.dm_we), 32'd1);
        chk("t1.dm_addr", bus.dm_addr, 32'h10);
        chk("t1.dm_wd",   bus.dm_wd, 32'hDEADBEEF);
        idle("t1.e2");
        chk("t1.empty",   32'(bus.empty), 32'd1);
        chk("t1.we_off",  32'(bus.dm_we), 32'd0);
        chk("t1.hold",    bus.dm_wd, 32'hDEADBEEF);

        // Five back-to-back stores, drained in order.
        for (int i = 0; i < 5; i++) store("t2.s", 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF);
        for (int i = 0; i < 3; i++) idle("t2.d");

        // RAW stall until the store has left the drain register.
        store("t4.s", 32'h20, 32'h0BAD_F00D, 4'hF);
        load("t4.l0", 32'h22);
        chk("t4.stall_drain", 32'(bus.ld_stall), 32'(!FWD_EN));
        load("t4.l1", 32'h22);
        chk("t4.stall_done", 32'(bus.ld_stall), 32'd0);
        store("t4.s2", 32'h20, 32'h1111_2222, 4'hF);
        load("t4.l2", 32'h24);
        chk("t4.other_word", 32'(bus.ld_stall), 32'd0);
        idle("t4.d");

`ifdef DM_STORE_BUFFER_LOAD_FWD_EN
        // Full-word forwarding; partial youngest match stalls.
        store("t5.s", 32'h40, 32'h12345678, 4'hF);
        load("t5.l", 32'h40);
        chk("t5.fwd_v",  32'(bus.ld_fwd_valid), 32'd1);
        chk("t5.fwd_d",  bus.ld_fwd_data, 32'h12345678);
        chk("t5.nstall", 32'(bus.ld_stall), 32'd0);
        store("t5.sp", 32'h40, 32'h0000_00AA, 4'h1);
        load("t5.lp", 32'h40);
        chk("t5.pstall", 32'(bus.ld_stall), 32'd1);
        idle("t5.d");
`endif

        // Reset while stores are pending and dm_we is high.
        store("t6.s0", 32'h200, 32'h5555_0000, 4'hF);
        store("t6.s1", 32'h204, 32'h5555_0001, 4'hF);
        store("t6.s2", 32'h208, 32'h5555_0002, 4'hF);
        chk("t6.we_before", 32'(bus.dm_we), 32'd1);
        @(negedge clk);
        bus.st_valid = 1'b0;
        bus.ld_valid = 1'b0;
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("t6.we_clr",  32'(bus.dm_we), 32'd0);
        chk("t6.pc_clr",  bus.dm_pc, 32'd0);
        chk("t6.empty",   32'(bus.empty), 32'd1);
        check_all("t6.rst", 1'b0, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle("t6.post");
            chk("t6.no_we", 32'(bus.dm_we), 32'd0);
        end

        // Random traffic on a small address window to provoke hazards.
        for (int n = 0; n < 400; n++) begin
            int unsigned r;
            logic [31:0] a;
            logic [3:0]  be;
            r  = $urandom_range(0, 9);
            a  = 32'($urandom_range(0, 7)) << 2 | 32'($urandom_range(0, 3));
            a  = a | (($urandom_range(0, 3) == 0) ? 32'h1000 : 32'h0);
            be = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(1, 14));
            if (r < 5) begin
                step("rnd.st", 1'b1, a, $urandom, be, $urandom, 1'b0, 32'd0);
            end else if (r < 8) begin
                step("rnd.ld", 1'b0, 32'd0, 32'd0, 4'd0, 32'd0, 1'b1, a);
            end else begin
                idle("rnd.idle");
            end
        end
        for (int i = 0; i < 3; i++) idle("end.d");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
